rate_detector: RTL and testbench

- Receive-side counterpart to the rate divider and display counter.
- Watches a single-cycle Tick stream (a rate divider Enable) and measures the interval between ticks.
- Recovers the 2-bit Speed code that produced the stream and mirrors the 4-bit display count.
- Used on the board to loop back and self-check the divider, and to detect a lost or irregular enable.

---
 rtl/rate_detector_if.sv | 12 +
 rtl/rate_detector.sv | 155 +++++++++++++++
 tb/tb_rate_detector.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rate_detector_if.sv
// Bundle for the tick stream under test and the recovered rate/lock status.
// The master modport drives Tick; the slave modport is the detector side.
interface rate_detector_if;
    logic       Tick;
    logic [1:0] SpeedOut;
    logic       Locked;
    logic       Error;
    logic [3:0] TickCount;

    modport master (output Tick, input SpeedOut, Locked, Error, TickCount);
    modport slave  (input Tick, output SpeedOut, Locked, Error, TickCount);
endinterface

// File: rtl/rate_detector.sv
// Measures the interval between single-cycle ticks, recovers the divider speed
// code, tracks lock stability and mirrors the 4-bit display tick count.
module rate_detector #(
    parameter int CLOCK_FREQUENCY = 100,
    parameter int LOCK_COUNT      = 2
) (
    input  logic           ClockIn,
    input  logic           Resetn,
    rate_detector_if.slave bus
);

    localparam int                MAX_INTERVAL = 4 * CLOCK_FREQUENCY;
    localparam int                CNT_W        = $clog2(MAX_INTERVAL) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX      = CNT_W'(MAX_INTERVAL);
    localparam logic [CNT_W-1:0]  IV_1X        = CNT_W'(CLOCK_FREQUENCY);
    localparam logic [CNT_W-1:0]  IV_2X        = CNT_W'(2 * CLOCK_FREQUENCY);
    localparam logic [2:0]        LOCK_TARGET  = 3'(LOCK_COUNT);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        LOCKED     = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       candidate, candidate_n;
    logic [2:0]       match, match_n;
    logic [1:0]       speed, speed_n;
    logic             locked, locked_n;
    logic             error, error_n;
    logic [3:0]       tick_count, tick_count_n;

    logic [CNT_W-1:0] interval;
    logic [1:0]       code;
    logic             code_valid;

    // cnt saturates at CNT_MAX, so cnt+1 always fits in CNT_W bits.
    assign interval = cnt + 1'b1;

    always_comb begin
        code       = 2'b00;
        code_valid = 1'b1;
        if (interval == CNT_W'(1))       code = 2'b00;
        else if (interval == IV_1X)      code = 2'b01;
        else if (interval == IV_2X)      code = 2'b10;
        else if (interval == CNT_MAX)    code = 2'b11;
        else                             code_valid = 1'b0;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned and infer a latch.
        state_n      = state;
        cnt_n        = cnt;
        candidate_n  = candidate;
        match_n      = match;
        speed_n      = speed;
        locked_n     = locked;
        error_n      = 1'b0;
        tick_count_n = tick_count;

        if (bus.Tick) begin
            cnt_n        = '0;
            tick_count_n = tick_count + 4'd1;
        end else if (cnt != CNT_MAX) begin
            cnt_n = cnt + 1'b1;
        end

        unique case (state)
            WAIT_FIRST: begin
                if (bus.Tick) begin
                    state_n = MEASURE;
                    match_n = 3'd0;
                end
            end
            MEASURE: begin
                if (bus.Tick) begin
                    if (!code_valid) begin
                        match_n = 3'd0;
                    end else if (code == candidate) begin
                        match_n = match + 3'd1;
                    end else begin
                        candidate_n = code;
                        match_n     = 3'd1;
                    end
                    if (match_n == LOCK_TARGET) begin
                        state_n  = LOCKED;
                        speed_n  = candidate_n;
                        locked_n = 1'b1;
                    end
                end else if (cnt == CNT_MAX) begin
                    state_n = WAIT_FIRST;
                    match_n = 3'd0;
                end
            end
            LOCKED: begin
                if (bus.Tick) begin
                    if (!code_valid) begin
                        state_n  = MEASURE;
                        error_n  = 1'b1;
                        locked_n = 1'b0;
                        match_n  = 3'd0;
                    end else if (code != candidate) begin
                        state_n     = MEASURE;
                        error_n     = 1'b1;
                        locked_n    = 1'b0;
                        candidate_n = code;
                        match_n     = 3'd1;
                    end
                end else if (cnt == CNT_MAX) begin
                    state_n  = WAIT_FIRST;
                    error_n  = 1'b1;
                    locked_n = 1'b0;
                    match_n  = 3'd0;
                end
            end
            default: begin
                state_n  = WAIT_FIRST;
                locked_n = 1'b0;
                match_n  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state      <= WAIT_FIRST;
            cnt        <= '0;
            candidate  <= 2'b00;
            match      <= 3'd0;
            speed      <= 2'b00;
            locked     <= 1'b0;
            error      <= 1'b0;
            tick_count <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state      <= state_n;
            cnt        <= cnt_n;
            candidate  <= candidate_n;
            match      <= match_n;
            speed      <= speed_n;
            locked     <= locked_n;
            error      <= error_n;
            tick_count <= tick_count_n;
        end
    end

    assign bus.SpeedOut  = speed;
    assign bus.Locked    = locked;
    assign bus.Error     = error;
    assign bus.TickCount = tick_count;

endmodule

// File: tb/tb_rate_detector.sv
// Directed bench for rate_detector with CLOCK_FREQUENCY=8, LOCK_COUNT=2
// (intervals: 1->00, 8->01, 16->10, 32->11; timeout at cnt==32).
module tb_rate_detector;

    logic clock;
    logic resetn;
    int   checks   = 0;
    int   fails    = 0;
    int   err_seen = 0;

    rate_detector_if bus ();

    rate_detector #(
        .CLOCK_FREQUENCY(8),
        .LOCK_COUNT     (2)
    ) dut (
        .ClockIn(clock),
        .Resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected end before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // Drive Tick for one rising edge, then sample just after that edge.
    task automatic edge_with(input logic t);
        bus.Tick = t;
        @(posedge clock);
        #1;
        if (bus.Error === 1'b1) err_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) edge_with(1'b0);
    endtask

    // n-1 quiet edges followed by a tick edge: measured interval is n.
    task automatic run_interval(input int n);
        idle(n - 1);
        edge_with(1'b1);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.Tick = 1'b0;
        resetn   = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("reset_speed", 4'(bus.SpeedOut), 4'd0);
        check("reset_locked", 4'(bus.Locked), 4'd0);
        check("reset_error", 4'(bus.Error), 4'd0);
        check("reset_tickcount", bus.TickCount, 4'd0);
        @(posedge clock);
        @(posedge clock);
        #1 resetn = 1'b1;
        idle(3);
        check("idle_locked", 4'(bus.Locked), 4'd0);
        check("idle_tickcount", bus.TickCount, 4'd0);

        // Period-8 stream: first tick starts timing, lock after the 3rd tick.
        err_seen = 0;
        edge_with(1'b1);
        run_interval(8);
        check("p8_not_yet_locked", 4'(bus.Locked), 4'd0);
        run_interval(8);
        check("p8_locked", 4'(bus.Locked), 4'd1);
        check("p8_speed", 4'(bus.SpeedOut), 4'd1);
        check("p8_tickcount", bus.TickCount, 4'd3);
        check("p8_no_error", 4'(err_seen), 4'd0);

        // Locked at 01, interval 16: one-cycle Error, then relock at 10.
        run_interval(16);
        check("chg_error_pulse", 4'(bus.Error), 4'd1);
        check("chg_unlocked", 4'(bus.Locked), 4'd0);
        check("chg_speed_holds", 4'(bus.SpeedOut), 4'd1);
        edge_with(1'b0);
        check("chg_error_one_cycle", 4'(bus.Error), 4'd0);
        idle(14);
        edge_with(1'b1);
        check("chg_relocked", 4'(bus.Locked), 4'd1);
        check("chg_speed_10", 4'(bus.SpeedOut), 4'd2);
        check("chg_tickcount", bus.TickCount, 4'd5);

        // Asynchronous reset between clock edges clears everything at once.
        idle(3);
        resetn = 1'b0;
        #1;
        check("async_speed", 4'(bus.SpeedOut), 4'd0);
        check("async_locked", 4'(bus.Locked), 4'd0);
        check("async_error", 4'(bus.Error), 4'd0);
        check("async_tickcount", bus.TickCount, 4'd0);
        #2 resetn = 1'b1;
        idle(3);
        check("post_reset_locked", 4'(bus.Locked), 4'd0);
        check("post_reset_tickcount", bus.TickCount, 4'd0);

        // Continuous Tick: interval 1, lock to 00 on the 3rd edge, count wraps.
        err_seen = 0;
        edge_with(1'b1);
        edge_with(1'b1);
        check("cont_not_yet_locked", 4'(bus.Locked), 4'd0);
        edge_with(1'b1);
        check("cont_locked", 4'(bus.Locked), 4'd1);
        check("cont_speed", 4'(bus.SpeedOut), 4'd0);
        for (int i = 0; i < 12; i++) edge_with(1'b1);
        check("cont_tickcount_15", bus.TickCount, 4'd15);
        edge_with(1'b1);
        check("cont_tickcount_wrap", bus.TickCount, 4'd0);
        check("cont_no_error", 4'(err_seen), 4'd0);

        // Move to interval 32 (code 11): one error on the change, then lock.
        run_interval(32);
        check("p32_change_error", 4'(bus.Error), 4'd1);
        run_interval(32);
        check("p32_locked", 4'(bus.Locked), 4'd1);
        check("p32_speed", 4'(bus.SpeedOut), 4'd3);
        check("p32_tickcount", bus.TickCount, 4'd2);

        // Stop Tick: cnt reaches 32 after 32 quiet edges, timeout on the 33rd.
        err_seen = 0;
        idle(32);
        check("to_still_locked", 4'(bus.Locked), 4'd1);
        check("to_no_early_error", 4'(err_seen), 4'd0);
        edge_with(1'b0);
        check("to_error_pulse", 4'(bus.Error), 4'd1);
        check("to_unlocked", 4'(bus.Locked), 4'd0);
        check("to_speed_holds", 4'(bus.SpeedOut), 4'd3);
        edge_with(1'b0);
        check("to_error_one_cycle", 4'(bus.Error), 4'd0);

        // Three ticks at interval 32 relock after timeout.
        edge_with(1'b1);
        run_interval(32);
        check("rl_not_yet_locked", 4'(bus.Locked), 4'd0);
        run_interval(32);
        check("rl_locked", 4'(bus.Locked), 4'd1);
        check("rl_speed", 4'(bus.SpeedOut), 4'd3);
        check("rl_tickcount", bus.TickCount, 4'd5);

        // Tick on the timeout edge counts as a tick of interval 33 (invalid).
        run_interval(33);
        check("edge33_error", 4'(bus.Error), 4'd1);
        check("edge33_unlocked", 4'(bus.Locked), 4'd0);
        check("edge33_tickcount", bus.TickCount, 4'd6);

        // Unlocked invalid intervals of 5: no lock, no error, count advances.
        err_seen = 0;
        run_interval(5);
        run_interval(5);
        run_interval(5);
        check("inv5_locked", 4'(bus.Locked), 4'd0);
        check("inv5_no_error", 4'(err_seen), 4'd0);
        check("inv5_tickcount", bus.TickCount, 4'd9);
        check("inv5_speed_holds", 4'(bus.SpeedOut), 4'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
